camera_stream_emulator: RTL and testbench

- Generates an OV7670-style camera byte stream (PCLK/VSYNC/HREF/8-bit data) from an internal test-pattern generator.
- It is the transmitter for the camera-capture downsampler. It replaces the physical camera in simulation and in board loopback, so the capture path, frame-buffer writes and colour-threshold logic can be checked against known pixels.
- Each pixel is RGB332 {R[2:0],G[2:0],B[1:0]}, sent as two bytes.

---
 rtl/camera_stream_emulator.sv | 184 ++++++++++++++++++
 tb/tb_camera_stream_emulator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_emulator.sv
// OV7670-style camera byte-stream source: PCLK/VSYNC/HREF/8-bit data carrying
// RGB332 test patterns, two bytes per pixel, for exercising the capture path.
module camera_stream_emulator #(
  parameter int H_ACTIVE      = 176,
  parameter int H_BLANK       = 20,
  parameter int V_ACTIVE      = 144,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int BAR_SHIFT     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [1:0]  PATTERN,
  input  logic [7:0]  SOLID_COLOR,
  output logic        PCLK_OUT,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  CAMERA_OUT,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_COUNT
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_AB = (V_ACTIVE > V_SYNC_LINES) ? V_ACTIVE : V_SYNC_LINES;
  localparam int MAX_CD = (V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES;
  localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW = $clog2(LINE);
  localparam int LW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [LW-1:0] line_q, line_d;
  logic [1:0]  pattern_q, pattern_d;
  logic [7:0]  solid_q, solid_d;
  logic        pclk_q;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  logic        start;
  logic        last_tick;
  logic        last_line;
  logic [7:0]  pix;

  function automatic int state_lines(input state_t s);
    case (s)
      ST_VSYNC:  return V_SYNC_LINES;
      ST_VBACK:  return V_BACK_LINES;
      ST_ACTIVE: return V_ACTIVE;
      ST_VFRONT: return V_FRONT_LINES;
      default:   return 1;
    endcase
  endfunction

  function automatic logic [7:0] pixel(input logic [1:0] pat, input logic [7:0] solid,
                                       input logic [XW-1:0] x, input logic [LW-1:0] y);
    logic [15:0] xw;
    logic [2:0]  i;
    logic        xl;
    logic        yt;
    xw = 16'(x);
    i  = 3'(xw >> BAR_SHIFT);
    xl = int'(x) < H_ACTIVE / 2;
    yt = int'(y) < V_ACTIVE / 2;
    case (pat)
      2'd0:    return solid;
      2'd1:    return {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
      2'd2:    return xw[7:0];
      default: return (xl && yt) ? 8'hE0 : (!xl && yt) ? 8'h03 : (xl && !yt) ? 8'h1C : 8'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d   = state_q;
    tick_d    = tick_q;
    line_d    = line_q;
    pattern_d = pattern_q;
    solid_d   = solid_q;
    count_d   = count_q;
    done_d    = 1'b0;
    start     = 1'b0;
    last_tick = (tick_q == TW'(LINE - 1));
    last_line = (line_q == LW'(state_lines(state_q) - 1));

    if (state_q == ST_IDLE) begin
      start = ENABLE;
    end else if (last_tick) begin
      tick_d = '0;
      if (last_line) begin
        line_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: begin
            done_d  = 1'b1;
            count_d = count_q + 1'b1;
            start   = ENABLE;
            state_d = ST_IDLE;
          end
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end

    // Pattern inputs are captured only here, so mid-frame changes wait a frame.
    if (start) begin
      state_d   = ST_VSYNC;
      tick_d    = '0;
      line_d    = '0;
      pattern_d = PATTERN;
      solid_d   = SOLID_COLOR;
    end

    // Outputs describe the tick being entered, so they register with the state.
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (tick_d < TW'(2 * H_ACTIVE));
    pix     = pixel(pattern_d, solid_d, XW'(tick_d >> 1), line_d);
    data_d  = '0;
    if (href_d) begin
      data_d = tick_d[0] ? {5'b00000, pix[7:5]} : {pix[4:2], 3'b000, pix[1:0]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      line_q    <= '0;
      pattern_q <= '0;
      solid_q   <= '0;
      pclk_q    <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pclk_q <= ~pclk_q;
      if (pclk_q) begin
        state_q   <= state_d;
        tick_q    <= tick_d;
        line_q    <= line_d;
        pattern_q <= pattern_d;
        solid_q   <= solid_d;
        vsync_q   <= vsync_d;
        href_q    <= href_d;
        data_q    <= data_d;
        done_q    <= done_d;
        count_q   <= count_d;
      end else begin
        // FRAME_DONE is a single-CLK pulse, not a full tick.
        done_q <= 1'b0;
      end
    end
  end

  assign PCLK_OUT    = pclk_q;
  assign VSYNC       = vsync_q;
  assign HREF        = href_q;
  assign CAMERA_OUT  = data_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_COUNT = count_q;

endmodule

// File: tb/tb_camera_stream_emulator.sv
// Scoreboard bench for camera_stream_emulator: expected per-tick stream is queued
// by the stimulus and compared by independent monitors.
module tb_camera_stream_emulator;

  localparam int HA = 4;
  localparam int HB = 3;
  localparam int VA = 3;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LINE_T = 2 * HA + HB;
  localparam int FRAME_TICKS = (VS + VB + VA + VF) * LINE_T;
  localparam int BUDGET = 2000;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } tick_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [1:0]  PATTERN;
  logic [7:0]  SOLID_COLOR;
  logic        PCLK_OUT;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  CAMERA_OUT;
  logic        FRAME_DONE;
  logic [15:0] FRAME_COUNT;

  int    total = 0;
  int    bad = 0;
  tick_t exp_q[$];
  int    in_frame;
  int    tick_i;
  int    frames_seen;
  int    done_pulses;
  // Bar colours for BAR_SHIFT=0: index = X, {R,G,B} replicated from index bits.
  logic [7:0] bar_lut [4] = '{8'h00, 8'h03, 8'h1C, 8'h1F};

  camera_stream_emulator #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_SYNC_LINES(VS),
    .V_BACK_LINES(VB), .V_FRONT_LINES(VF), .BAR_SHIFT(0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PATTERN(PATTERN),
    .SOLID_COLOR(SOLID_COLOR), .PCLK_OUT(PCLK_OUT), .VSYNC(VSYNC), .HREF(HREF),
    .CAMERA_OUT(CAMERA_OUT), .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  task automatic push_frame(input int pat, input logic [7:0] solid);
    tick_t r;
    int ln, pos, x, y;
    logic [7:0] p;
    for (int t = 0; t < FRAME_TICKS; t++) begin
      ln = t / LINE_T;
      pos = t % LINE_T;
      r = '0;
      if (ln < VS) begin
        r.vs = 1'b1;
      end else if (ln >= VS + VB && ln < VS + VB + VA && pos < 2 * HA) begin
        x = pos / 2;
        y = ln - VS - VB;
        case (pat)
          0:       p = solid;
          1:       p = bar_lut[x];
          2:       p = 8'(x);
          default: p = (x < HA / 2) ? ((y < VA / 2) ? 8'hE0 : 8'h1C)
                                    : ((y < VA / 2) ? 8'h03 : 8'h00);
        endcase
        r.hr = 1'b1;
        r.d = (pos % 2 == 0) ? {p[4:2], 3'b000, p[1:0]} : {5'b00000, p[7:5]};
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_tick(input int f, input int t);
    int n = 0;
    while (!(frames_seen == f && in_frame != 0 && tick_i == t) && n < BUDGET) begin
      @(posedge PCLK_OUT);
      #2;
      n++;
    end
    if (n >= BUDGET) fail($sformatf("wait_tick timeout frame %0d tick %0d", f, t));
  endtask

  task automatic wait_frames(input int f);
    int n = 0;
    while (frames_seen < f && n < BUDGET) begin
      @(posedge PCLK_OUT);
      #2;
      n++;
    end
    if (n >= BUDGET) fail($sformatf("wait_frames timeout %0d", f));
  endtask

  // Tick monitor: compares every frame tick against the queue, idle ticks against 0.
  initial begin
    tick_t r;
    in_frame = 0;
    tick_i = 0;
    frames_seen = 0;
    forever begin
      @(posedge PCLK_OUT or posedge RESET);
      if (RESET) begin
        in_frame = 0;
        tick_i = 0;
        frames_seen = 0;
        exp_q.delete();
      end else begin
        #1;
        if (in_frame == 0 && VSYNC) begin
          in_frame = 1;
          tick_i = 0;
        end
        if (in_frame != 0) begin
          if (exp_q.size() == 0) begin
            fail($sformatf("unexpected frame tick %0d", tick_i));
          end else begin
            r = exp_q.pop_front();
            check($sformatf("tick f%0d t%0d {vs,href,data}", frames_seen, tick_i),
                  {22'd0, VSYNC, HREF, CAMERA_OUT}, {22'd0, r});
          end
          tick_i++;
          if (tick_i == FRAME_TICKS) begin
            in_frame = 0;
            frames_seen++;
          end
        end else begin
          check("idle outputs", {22'd0, VSYNC, HREF, CAMERA_OUT}, 32'd0);
        end
      end
    end
  end

  // FRAME_DONE monitor: one CLK wide, right after the last frame tick.
  initial begin
    done_pulses = 0;
    forever begin
      @(negedge PCLK_OUT or posedge RESET);
      if (RESET) begin
        done_pulses = 0;
      end else begin
        #1;
        if (FRAME_DONE) begin
          check("done alignment", done_pulses + 1, frames_seen);
          check("frame count", {16'd0, FRAME_COUNT}, 32'(frames_seen));
          done_pulses++;
          @(posedge CLK);
          #1;
          check("done width", {31'd0, FRAME_DONE}, 32'd0);
        end
      end
    end
  end

  // Stability monitor: outputs at each PCLK rise equal those of the prior CLK.
  initial begin
    logic [9:0] snap;
    forever begin
      @(negedge CLK);
      if (!PCLK_OUT && !RESET) begin
        snap = {VSYNC, HREF, CAMERA_OUT};
        @(posedge CLK);
        #1;
        if (PCLK_OUT && !RESET) check("setup hold", {22'd0, VSYNC, HREF, CAMERA_OUT}, {22'd0, snap});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    ENABLE = 1'b0;
    PATTERN = 2'd0;
    SOLID_COLOR = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset outputs", {PCLK_OUT, VSYNC, HREF, CAMERA_OUT, FRAME_DONE, FRAME_COUNT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("pclk first edge", {31'd0, PCLK_OUT}, 32'd1);

    // Four back-to-back frames; each pattern change lands mid-frame.
    PATTERN = 2'd0;
    SOLID_COLOR = 8'hE3;
    push_frame(0, 8'hE3);
    ENABLE = 1'b1;
    wait_tick(0, 30);
    PATTERN = 2'd3;
    SOLID_COLOR = 8'h55;
    push_frame(3, 8'h55);
    wait_tick(1, 30);
    PATTERN = 2'd1;
    push_frame(1, 8'h55);
    wait_tick(2, 30);
    PATTERN = 2'd2;
    push_frame(2, 8'h55);
    wait_tick(3, 34);
    ENABLE = 1'b0;
    wait_frames(4);
    repeat (4) @(posedge PCLK_OUT);
    #2;
    check("count after drop", {16'd0, FRAME_COUNT}, 32'd4);

    // Re-enable: VSYNC must rise at the very next update edge.
    PATTERN = 2'd0;
    SOLID_COLOR = 8'h1C;
    push_frame(0, 8'h1C);
    ENABLE = 1'b1;
    @(negedge PCLK_OUT);
    #1;
    check("vsync restart", {31'd0, VSYNC}, 32'd1);

    // Async reset while pixel X=2 byte 0 is on the bus.
    wait_tick(4, 27);
    check("x2 byte before reset", {23'd0, HREF, CAMERA_OUT}, {23'd0, 1'b1, 8'hE0});
    RESET = 1'b1;
    #1;
    check("async reset outputs", {PCLK_OUT, VSYNC, HREF, CAMERA_OUT, FRAME_DONE, FRAME_COUNT}, 32'd0);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Pattern edits between frames: only the value present at VSYNC entry counts.
    repeat (3) @(posedge PCLK_OUT);
    #2;
    PATTERN = 2'd2;
    repeat (3) @(posedge PCLK_OUT);
    #2;
    PATTERN = 2'd3;
    SOLID_COLOR = 8'hFF;
    push_frame(3, 8'hFF);
    ENABLE = 1'b1;
    wait_tick(0, 5);
    PATTERN = 2'd1;
    SOLID_COLOR = 8'h00;
    ENABLE = 1'b0;
    wait_frames(1);
    repeat (4) @(posedge PCLK_OUT);
    #2;
    check("count after reset frame", {16'd0, FRAME_COUNT}, 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("done pulses", 32'(done_pulses), 32'(frames_seen));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
